// File: rtl/reg_file_2w4r_if.sv
// Write-back/decode bundle for the dual-issue register file: two write lanes,
// four operand read ports and the registered write-collision flag.
interface reg_file_2w4r_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              WE1;
    logic [ADDR_W-1:0] WA1;
    logic [DATA_W-1:0] WD1;
    logic              WE2;
    logic [ADDR_W-1:0] WA2;
    logic [DATA_W-1:0] WD2;
    logic [ADDR_W-1:0] RA1;
    logic [ADDR_W-1:0] RA2;
    logic [ADDR_W-1:0] RA3;
    logic [ADDR_W-1:0] RA4;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [DATA_W-1:0] RD3;
    logic [DATA_W-1:0] RD4;
    logic              WR_CONFLICT;

    modport master (
        output WE1, WA1, WD1, WE2, WA2, WD2, RA1, RA2, RA3, RA4,
        input  RD1, RD2, RD3, RD4, WR_CONFLICT
    );

    modport slave (
        input  WE1, WA1, WD1, WE2, WA2, WD2, RA1, RA2, RA3, RA4,
        output RD1, RD2, RD3, RD4, WR_CONFLICT
    );
endinterface

// File: rtl/reg_file_2w4r.sv
// Dual-issue integer register file: 2 write lanes (lane 2 wins collisions),
// 4 combinational read ports with optional same-cycle write-to-read bypass.
module reg_file_2w4r #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_2w4r_if.slave       bus
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] ra   [4];
    logic [DATA_W-1:0] rd   [4];
    logic              conflict_reg;
    logic              conflict_next;

    // r0 has no storage at all, so writes to it vanish by construction
    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (bus.WE2 && bus.WA2 == ADDR_W'(gi)) begin
                    q_reg <= bus.WD2;
                end else if (bus.WE1 && bus.WA1 == ADDR_W'(gi)) begin
                    q_reg <= bus.WD1;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    assign ra[0] = bus.RA1;
    assign ra[1] = bus.RA2;
    assign ra[2] = bus.RA3;
    assign ra[3] = bus.RA4;

    // Lane 2 is younger in program order, so it takes precedence on the bypass too
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_val;

            always_comb begin
                rd_val = '0;
                if (ra[gi] == '0 || int'(ra[gi]) >= NREGS) begin
                    rd_val = '0;
                end else if (BYPASS != 0 && rst_n && bus.WE2 && bus.WA2 == ra[gi]) begin
                    rd_val = bus.WD2;
                end else if (BYPASS != 0 && rst_n && bus.WE1 && bus.WA1 == ra[gi]) begin
                    rd_val = bus.WD1;
                end else begin
                    rd_val = regs[ra[gi]];
                end
            end

            assign rd[gi] = rd_val;
        end
    endgenerate

    assign bus.RD1 = rd[0];
    assign bus.RD2 = rd[1];
    assign bus.RD3 = rd[2];
    assign bus.RD4 = rd[3];

    always_comb begin
        conflict_next = bus.WE1 && bus.WE2 && (bus.WA1 == bus.WA2) && (bus.WA1 != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_reg <= 1'b0;
        end else begin
            conflict_reg <= conflict_next;
        end
    end

    assign bus.WR_CONFLICT = conflict_reg;

endmodule

// File: tb/tb_reg_file_2w4r.sv
// Bench for reg_file_2w4r: a bypassing and a non-bypassing instance share one
// stimulus stream and are compared against an array-based reference model.
module tb_reg_file_2w4r;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [31:0] mem [32];
    logic        exp_conf;

    reg_file_2w4r_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
    reg_file_2w4r_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    assign bus_n.WE1 = bus_b.WE1;
    assign bus_n.WA1 = bus_b.WA1;
    assign bus_n.WD1 = bus_b.WD1;
    assign bus_n.WE2 = bus_b.WE2;
    assign bus_n.WA2 = bus_b.WA2;
    assign bus_n.WD2 = bus_b.WD2;
    assign bus_n.RA1 = bus_b.RA1;
    assign bus_n.RA2 = bus_b.RA2;
    assign bus_n.RA3 = bus_b.RA3;
    assign bus_n.RA4 = bus_b.RA4;

    reg_file_2w4r #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .BYPASS(1)) dut_byp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    reg_file_2w4r #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .BYPASS(0)) dut_nob (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read rule: r0 is zero, then same-cycle lane 2, then lane 1, then stored value
    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && rst_n && bus_b.WE2 && bus_b.WA2 == a) return bus_b.WD2;
        if (byp && rst_n && bus_b.WE1 && bus_b.WA1 == a) return bus_b.WD1;
        return mem[a];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            exp_conf = 1'b0;
        end else begin
            exp_conf = bus_b.WE1 && bus_b.WE2 && bus_b.WA1 == bus_b.WA2 && bus_b.WA1 != 5'd0;
            // Apply lane 1 before lane 2 so the younger lane overwrites
            if (bus_b.WE1 && bus_b.WA1 != 5'd0) mem[bus_b.WA1] = bus_b.WD1;
            if (bus_b.WE2 && bus_b.WA2 != 5'd0) mem[bus_b.WA2] = bus_b.WD2;
        end
    endtask

    task automatic cycle();
        logic [4:0]  ra [4];
        logic [31:0] ob [4];
        logic [31:0] on [4];
        #1;
        ra = '{bus_b.RA1, bus_b.RA2, bus_b.RA3, bus_b.RA4};
        ob = '{bus_b.RD1, bus_b.RD2, bus_b.RD3, bus_b.RD4};
        on = '{bus_n.RD1, bus_n.RD2, bus_n.RD3, bus_n.RD4};
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rd%0d_byp", p + 1), ob[p], model_read(ra[p], 1'b1));
            chk($sformatf("rd%0d_nob", p + 1), on[p], model_read(ra[p], 1'b0));
        end
        $display("cyc %0d rst_n=%0b we1=%0b wa1=%0d wd1=%h we2=%0b wa2=%0d wd2=%h ra=%0d/%0d/%0d/%0d rd=%h/%h/%h/%h",
                 cyc, rst_n, bus_b.WE1, bus_b.WA1, bus_b.WD1, bus_b.WE2, bus_b.WA2, bus_b.WD2,
                 ra[0], ra[1], ra[2], ra[3], ob[0], ob[1], ob[2], ob[3]);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("conflict_byp", 32'(bus_b.WR_CONFLICT), 32'(exp_conf));
        chk("conflict_nob", 32'(bus_n.WR_CONFLICT), 32'(exp_conf));
    endtask

    task automatic idle();
        bus_b.WE1 = 1'b0; bus_b.WA1 = 5'd0; bus_b.WD1 = 32'h0;
        bus_b.WE2 = 1'b0; bus_b.WA2 = 5'd0; bus_b.WD2 = 32'h0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        bus_b.WE1 = 1'b1; bus_b.WA1 = a; bus_b.WD1 = d;
    endtask

    task automatic wr2(input logic [4:0] a, input logic [31:0] d);
        bus_b.WE2 = 1'b1; bus_b.WA2 = a; bus_b.WD2 = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3, input logic [4:0] a4);
        bus_b.RA1 = a1; bus_b.RA2 = a2; bus_b.RA3 = a3; bus_b.RA4 = a4;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        exp_conf = 1'b0;
        rst_n = 1'b0;
        idle();
        rd(0, 0, 0, 0);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Reset clears a preloaded register
        wr1(5, 32'h1234); cycle();
        idle(); rd(5, 0, 0, 0);
        #1 chk("preload_r5", bus_b.RD1, 32'h1234);
        cycle();
        rst_n = 1'b0; cycle();
        rst_n = 1'b1;
        #1 chk("reset_r5", bus_b.RD1, 32'h0);
        chk("reset_conf", 32'(bus_b.WR_CONFLICT), 32'h0);
        cycle();

        // r0 guard, with and without bypass
        wr1(0, 32'hFFFF_FFFF); rd(0, 0, 0, 0);
        #1 chk("r0_same", bus_b.RD1, 32'h0);
        cycle();
        chk("r0_conf", 32'(bus_b.WR_CONFLICT), 32'h0);
        idle();
        #1 chk("r0_next", bus_b.RD1, 32'h0);
        cycle();

        // Independent dual write
        wr1(3, 32'hA); wr2(4, 32'hB); cycle();
        chk("dual_conf", 32'(bus_b.WR_CONFLICT), 32'h0);
        idle(); rd(3, 4, 3, 4);
        #1 chk("dual_r3", bus_n.RD1, 32'hA);
        chk("dual_r4", bus_n.RD2, 32'hB);
        cycle();

        // Collision: lane 2 wins, flag pulses once
        wr1(7, 32'h11); wr2(7, 32'h22); rd(7, 7, 7, 7);
        #1 chk("coll_byp_same", bus_b.RD1, 32'h22);
        cycle();
        chk("coll_flag", 32'(bus_b.WR_CONFLICT), 32'h1);
        idle();
        #1 chk("coll_r7", bus_n.RD1, 32'h22);
        cycle();
        chk("coll_clear", 32'(bus_b.WR_CONFLICT), 32'h0);

        // Back-to-back collisions give consecutive ones
        wr1(8, 32'h1); wr2(8, 32'h2); cycle();
        chk("coll2_first", 32'(bus_b.WR_CONFLICT), 32'h1);
        wr1(8, 32'h3); wr2(8, 32'h4); cycle();
        chk("coll2_second", 32'(bus_b.WR_CONFLICT), 32'h1);
        idle(); cycle();
        chk("coll2_clear", 32'(bus_b.WR_CONFLICT), 32'h0);

        // Collision on r0 does not flag
        wr1(0, 32'h5); wr2(0, 32'h6); cycle();
        chk("coll_r0", 32'(bus_b.WR_CONFLICT), 32'h0);

        // Bypass vs array-only reads
        idle(); wr1(9, 32'h5); cycle();
        wr1(9, 32'h6); rd(0, 0, 9, 0);
        #1 chk("byp_rd3", bus_b.RD3, 32'h6);
        chk("nobyp_rd3", bus_n.RD3, 32'h5);
        cycle();
        idle();
        #1 chk("after_rd3", bus_n.RD3, 32'h6);
        cycle();

        // Reset mid-write: bypass suppressed, write dropped
        wr2(12, 32'h77); cycle();
        rst_n = 1'b0; idle(); wr2(12, 32'h99); rd(12, 12, 12, 12);
        #1 chk("rst_no_byp", bus_b.RD1, 32'h77);
        cycle();
        rst_n = 1'b1; idle();
        #1 chk("rst_r12", bus_b.RD1, 32'h0);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            bus_b.WE1 = 1'($urandom_range(0, 1));
            bus_b.WA1 = rand_addr();
            bus_b.WD1 = $urandom;
            bus_b.WE2 = 1'($urandom_range(0, 1));
            bus_b.WA2 = rand_addr();
            bus_b.WD2 = $urandom;
            rd(rand_addr(), rand_addr(), rand_addr(), rand_addr());
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
